// File: rtl/fir_input_feeder.sv
// Buffers source samples in a FIFO and issues one to the FIR filter per rising edge of ready_for_input.
// Issue is registered (one cycle after the rise, or one cycle after the push when armed empty); in_ready drops at full.
module fir_input_feeder #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         FIR_input,
  output logic                     input_valid,
  input  logic                     ready_for_input,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, ARMED, ISSUE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             rdy_q, rdy_d;
  logic [WIDTH-1:0] fir_input_q, fir_input_d;
  logic             input_valid_q, input_valid_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic push, pop, rise, credit;

  assign in_ready    = (level_q != LW'(DEPTH));
  assign level       = level_q;
  assign FIR_input   = fir_input_q;
  assign input_valid = input_valid_q;

  always_comb begin
    push   = in_valid && in_ready;
    rise   = ready_for_input && !rdy_q;
    credit = (state_q == ARMED);
    // A rise may issue in its own cycle; head is read from storage only, so no push bypass.
    pop    = (credit || rise) && (level_q != '0);

    rdy_d    = ready_for_input;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);

    level_d = level_q;
    if (push && !pop)
      level_d = level_q + LW'(1);
    else if (pop && !push)
      level_d = level_q - LW'(1);

    fir_input_d   = pop ? mem_q[rd_ptr_q] : fir_input_q;
    input_valid_d = pop;

    // Clear wins over set: an issue consumes the credit even on the rise cycle.
    if (pop)
      state_d = ISSUE;
    else if (credit || rise)
      state_d = ARMED;
    else
      state_d = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      rdy_q         <= 1'b0;
      fir_input_q   <= '0;
      input_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      rdy_q         <= rdy_d;
      fir_input_q   <= fir_input_d;
      input_valid_q <= input_valid_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_fir_input_feeder.sv
// Directed bench for fir_input_feeder: reset, basic issue, armed-empty, back-pressure, wrap and reset mid-operation.
module tb_fir_input_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] FIR_input;
  logic        input_valid;
  logic        ready_for_input = 1'b0;
  logic [3:0]  level;

  int n_assert = 0;
  int n_fail   = 0;

  fir_input_feeder #(.WIDTH(16), .DEPTH(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .FIR_input       (FIR_input),
    .input_valid     (input_valid),
    .ready_for_input (ready_for_input),
    .level           (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values, checked while reset is held and before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk("rst_valid",    32'(input_valid), 32'd0);
    chk("rst_fir",      32'(FIR_input),   32'h0);
    chk("rst_level",    32'(level),       32'd0);
    chk("rst_in_ready", 32'(in_ready),    32'd1);
    tick;
    tick;
    reset = 1'b0;
    tick;

    // Basic issue: three pushes with the filter busy, then a rising edge.
    in_valid = 1'b1;
    in_data  = 16'h0011;
    tick;
    in_data  = 16'h0022;
    tick;
    in_data  = 16'h0033;
    tick;
    in_valid = 1'b0;
    chk("basic_level3",  32'(level),       32'd3);
    chk("basic_novalid", 32'(input_valid), 32'd0);
    ready_for_input = 1'b1;
    tick;
    chk("basic_valid1", 32'(input_valid), 32'd1);
    chk("basic_fir1",   32'(FIR_input),   32'h0011);
    chk("basic_level2", 32'(level),       32'd2);
    tick;
    chk("basic_single_pulse", 32'(input_valid), 32'd0);
    chk("basic_fir_hold",     32'(FIR_input),   32'h0011);
    tick;
    chk("basic_level_held_high", 32'(input_valid), 32'd0);
    chk("basic_level2_hold",     32'(level),       32'd2);
    ready_for_input = 1'b0;
    tick;
    ready_for_input = 1'b1;
    tick;
    chk("basic_valid2", 32'(input_valid), 32'd1);
    chk("basic_fir2",   32'(FIR_input),   32'h0022);
    chk("basic_level1", 32'(level),       32'd1);
    tick;
    chk("basic_valid2_end", 32'(input_valid), 32'd0);
    ready_for_input = 1'b0;
    tick;
    ready_for_input = 1'b1;
    tick;
    chk("basic_fir3",   32'(FIR_input), 32'h0033);
    chk("basic_empty",  32'(level),     32'd0);

    // Armed while empty: credit held until a push, then issue one cycle later.
    ready_for_input = 1'b0;
    tick;
    ready_for_input = 1'b1;
    tick;
    chk("armed_no_pulse", 32'(input_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("armed_wait_no_pulse", 32'(input_valid), 32'd0);
    end
    in_valid = 1'b1;
    in_data  = 16'h1234;
    tick;
    in_valid = 1'b0;
    chk("armed_push_level", 32'(level),       32'd1);
    chk("armed_no_bypass",  32'(input_valid), 32'd0);
    tick;
    chk("armed_valid", 32'(input_valid), 32'd1);
    chk("armed_fir",   32'(FIR_input),   32'h1234);
    chk("armed_level", 32'(level),       32'd0);
    tick;
    chk("armed_valid_end", 32'(input_valid), 32'd0);

    // Full and back-pressure: eight pushes fill the FIFO, the ninth waits for a pop.
    ready_for_input = 1'b0;
    tick;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(32'h00A0 + i);
      tick;
    end
    chk("full_level",    32'(level),    32'd8);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_data = 16'h00A8;
    tick;
    chk("full_ninth_held",  32'(level),    32'd8);
    chk("full_ninth_ready", 32'(in_ready), 32'd0);
    ready_for_input = 1'b1;
    tick;
    chk("full_pop_valid",    32'(input_valid), 32'd1);
    chk("full_pop_fir",      32'(FIR_input),   32'h00A0);
    chk("full_pop_level",    32'(level),       32'd7);
    chk("full_pop_in_ready", 32'(in_ready),    32'd1);
    tick;
    in_valid = 1'b0;
    chk("full_ninth_accepted", 32'(level),    32'd8);
    chk("full_again_ready",    32'(in_ready), 32'd0);

    // Drain across the pointer wrap: order must be A1..A8.
    for (int i = 1; i <= 8; i++) begin
      ready_for_input = 1'b0;
      tick;
      ready_for_input = 1'b1;
      tick;
      chk("wrap_valid", 32'(input_valid), 32'd1);
      chk("wrap_fir",   32'(FIR_input),   32'h00A0 + 32'(i));
    end
    chk("wrap_empty", 32'(level), 32'd0);

    // Reset mid-operation with five samples buffered and a rise pending.
    ready_for_input = 1'b0;
    tick;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 16'(32'h0050 + i);
      tick;
    end
    in_valid = 1'b0;
    chk("mid_level5", 32'(level), 32'd5);
    ready_for_input = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_level",    32'(level),       32'd0);
    chk("mid_rst_valid",    32'(input_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready),    32'd1);
    chk("mid_rst_fir",      32'(FIR_input),   32'h0);
    ready_for_input = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    tick;
    tick;
    chk("mid_idle_no_pulse", 32'(input_valid), 32'd0);
    in_valid = 1'b1;
    in_data  = 16'h0077;
    tick;
    in_valid = 1'b0;
    chk("mid_new_level", 32'(level), 32'd1);
    tick;
    chk("mid_no_credit1", 32'(input_valid), 32'd0);
    tick;
    chk("mid_no_credit2", 32'(input_valid), 32'd0);
    chk("mid_level_kept", 32'(level),       32'd1);
    ready_for_input = 1'b1;
    tick;
    chk("mid_fresh_valid", 32'(input_valid), 32'd1);
    chk("mid_fresh_fir",   32'(FIR_input),   32'h0077);
    chk("mid_fresh_level", 32'(level),       32'd0);

    // Filter ready held high through reset: first sampled cycle arms the feeder.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    chk("post_rst_armed_no_pulse", 32'(input_valid), 32'd0);
    in_valid = 1'b1;
    in_data  = 16'h0088;
    tick;
    in_valid = 1'b0;
    chk("post_rst_push_no_pulse", 32'(input_valid), 32'd0);
    tick;
    chk("post_rst_valid", 32'(input_valid), 32'd1);
    chk("post_rst_fir",   32'(FIR_input),   32'h0088);
    tick;
    chk("post_rst_valid_end", 32'(input_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_input_feeder.md
# fir_input_feeder

Upstream stage of `FIR_filter`. It buffers samples from a streaming source in a small FIFO and hands them to the filter one at a time, using the filter's `ready_for_input` / `input_valid` handshake. Each sample is issued as a single-cycle `input_valid` pulse, with `FIR_input` held stable until the next issue. Samples are never dropped, and the source is back-pressured when the FIFO is full.

## Interface
Parameters:
- `WIDTH`, 16, sample width; must match the filter's `WIDTH`.
- `DEPTH`, 8, FIFO depth; a power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `in_data`  in  WIDTH  source sample.
- `in_valid`  in  1  source offers `in_data` this cycle.
- `in_ready`  out  1  FIFO can accept; combinational, equal to `level != DEPTH`.
- `FIR_input`  out  WIDTH  sample to filter; registered.
- `input_valid`  out  1  one-cycle issue pulse to the filter; registered.
- `ready_for_input`  in  1  filter idle and able to accept a sample.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH; registered.

## Operation
FIFO:
- Circular buffer with `DEPTH` entries.
- Write and read pointers are $clog2(DEPTH) bits and wrap naturally.
- Push occurs when `in_valid && in_ready`; `in_data` is written at the write pointer.
- Pop occurs on issue (below).
- Push and pop in the same cycle leave `level` unchanged; both pointers advance.
- No bypass: a sample pushed into an empty FIFO is first issuable on the following cycle.

Credit tracking:
- `rdy_q` is a register that samples `ready_for_input` every cycle.
- `rise = ready_for_input && !rdy_q` (combinational).
- `credit` register:
  - set on `rise`;
  - cleared on issue;
  - if set and clear happen together, clear wins;
  - `rise` can itself trigger an issue in the same cycle.
- Exactly one sample is issued per rising edge of `ready_for_input`. A level that stays high never issues a second sample.

Issue:
- Condition: `(credit || rise) && level != 0`.
- On issue, at the clock edge:
  - `FIR_input <= head`;
  - `input_valid <= 1`;
  - read pointer advances;
  - `credit <= 0`.
- Otherwise `input_valid <= 0` and `FIR_input` holds its value.

Credit retention:
- A credit with an empty FIFO is retained.
- The issue then fires on the first cycle the FIFO becomes non-empty, i.e. one cycle after the push edge.

States:
- `IDLE`: `credit = 0`.
- `ARMED`: `credit = 1`, waiting for data.
- `ISSUE`: `input_valid = 1`.
- Transitions:
  - `IDLE` → `ISSUE` on `rise` with data.
  - `IDLE` → `ARMED` on `rise` without data.
  - `ARMED` → `ISSUE` when data is available.
  - `ISSUE` → `IDLE` always.
  - `ISSUE` → `ARMED` is not possible: a new `rise` requires `ready_for_input` to fall and rise again, and the filter drops it once loading starts.

Reset (asynchronous):
- Pointers = 0, `level` = 0, `credit` = 0, `rdy_q` = 0.
- `input_valid` = 0, `FIR_input` = 0, `in_ready` = 1.
- FIFO contents are don't-care.
- After reset, if the filter holds `ready_for_input` high, the first sampled cycle counts as a `rise`, which arms the feeder.
- Reset mid-operation discards all buffered samples and any pending credit.

## Timing
- Latency with data present: `ready_for_input` sampled high after low at edge T → `input_valid` = 1 during cycle T..T+1, and `FIR_input` equals the oldest sample.
- Latency when armed but empty: push at edge T → `level` = 1 after T → issue at edge T+1 → `input_valid` is high after T+1.
- Back-pressure: `in_ready` falls in the same cycle `level` reaches `DEPTH`. A pop frees one slot, and `in_ready` = 1 the cycle after the pop edge.
- `in_ready` has no combinational path from `ready_for_input`; `input_valid` has no combinational path from any input.
- `input_valid` is never high on two consecutive cycles.

## Test plan
- **Reset values:** assert `reset` → immediately `input_valid` = 0, `FIR_input` = 0, `level` = 0, `in_ready` = 1.
- **Basic issue:** push 0x0011, 0x0022, 0x0033 with `ready_for_input` low, then pulse it high → exactly one `input_valid` pulse carrying 0x0011, `level` goes 3 → 2. A second rising edge issues 0x0022.
- **Armed empty:** raise `ready_for_input` with the FIFO empty, then push 0x1234 five cycles later → `input_valid` occurs one cycle after the push with `FIR_input` = 0x1234, and no pulse occurs before that.
- **Full / back-pressure:** push 9 samples at `DEPTH` = 8 → `in_ready` = 0 after the 8th push and the 9th is held. One issue later the 9th is accepted and `level` returns to 8.
- **Wrap-around:** drive 20 samples (values 0..19) through the real `FIR_filter` (`WIDTH` 16, `LENGHT` 64) → the filter receives 0..19 in order, with no duplicates or losses; compare against `outputs.txt` entries 0..19.
- **Reset mid-operation:** assert `reset` with `level` = 5 and `credit` set → `level` = 0 and there is no `input_valid` pulse until new data is pushed and a fresh `rise` is seen.
